// File: rtl/game_pkg.sv
// Shared types and constants for the reaction-game round controller and scorer.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    GO     = 2'd2,
    RESULT = 2'd3
  } round_state_t;

  typedef enum logic {
    PLAYER_1 = 1'b0,
    PLAYER_2 = 1'b1
  } player_idx_t;

  // Galois right-shift mask for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for a raw button plus a one-cycle rising-edge pulse.
module btn_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 & ~s3;

endmodule

// File: rtl/round_referee.sv
// Round controller: random delay, GO, first-press arbitration, held win levels.
// Optional build macro FALSE_START_PENALTY_EN enables the false-start penalty in WAIT.
module round_referee
  import game_pkg::*;
#(
  parameter int          MIN_DELAY = 50_000_000,
  parameter int          RAND_BITS = 26,
  parameter int          TIMEOUT   = 100_000_000,
  parameter int          HOLD      = 25_000_000,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_0001
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       p1_btn,
  input  logic       p2_btn,
  input  logic       game_over,
  output logic       p1vic,
  output logic       p2vic,
  output logic       tie,
  output logic       go_led,
  output logic [1:0] state_dbg
);

  localparam int MAX_WAIT = MIN_DELAY + (1 << RAND_BITS);
  localparam int MAX_A    = (MAX_WAIT > TIMEOUT) ? MAX_WAIT : TIMEOUT;
  localparam int CNT_MAX  = (MAX_A > HOLD) ? MAX_A : HOLD;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  // Loads are N-1: the zero check precedes the decrement, so each phase spans exactly N cycles.
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  logic start_p, p1_p, p2_p;

  btn_sync_edge u_sync_start (.clock(clock), .reset(reset), .btn(start_btn), .pulse(start_p));
  btn_sync_edge u_sync_p1    (.clock(clock), .reset(reset), .btn(p1_btn),    .pulse(p1_p));
  btn_sync_edge u_sync_p2    (.clock(clock), .reset(reset), .btn(p2_btn),    .pulse(p2_p));

  round_state_t     state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [31:0]      lfsr;
  logic             p1_q, p2_q, tie_q, go_q;
  logic             p1_n, p2_n, tie_n, go_n;
  logic [CNT_W-1:0] wait_load;

  assign wait_load = CNT_W'(MIN_DELAY - 1) + CNT_W'(lfsr[RAND_BITS-1:0]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      lfsr  <= LFSR_SEED;
      p1_q  <= 1'b0;
      p2_q  <= 1'b0;
      tie_q <= 1'b0;
      go_q  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      lfsr  <= lfsr_step(lfsr);
      p1_q  <= p1_n;
      p2_q  <= p2_n;
      tie_q <= tie_n;
      go_q  <= go_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    p1_n    = p1_q;
    p2_n    = p2_q;
    tie_n   = tie_q;
    case (state)
      IDLE: begin
        p1_n  = 1'b0;
        p2_n  = 1'b0;
        tie_n = 1'b0;
        if (start_p && !game_over) begin
          state_n = WAIT;
          cnt_n   = wait_load;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_n = GO;
          cnt_n   = TIMEOUT_LOAD;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
`ifdef FALSE_START_PENALTY_EN
        // A lone early press hands the round to the opponent; a joint one just restarts the delay.
        if (p1_p && p2_p) begin
          state_n = WAIT;
          cnt_n   = wait_load;
        end else if (p1_p) begin
          state_n = RESULT;
          cnt_n   = HOLD_LOAD;
          p2_n    = 1'b1;
        end else if (p2_p) begin
          state_n = RESULT;
          cnt_n   = HOLD_LOAD;
          p1_n    = 1'b1;
        end
`endif
      end
      GO: begin
        if (p1_p && p2_p) begin
          state_n = RESULT;
          cnt_n   = HOLD_LOAD;
          tie_n   = 1'b1;
        end else if (p1_p) begin
          state_n = RESULT;
          cnt_n   = HOLD_LOAD;
          p1_n    = 1'b1;
        end else if (p2_p) begin
          state_n = RESULT;
          cnt_n   = HOLD_LOAD;
          p2_n    = 1'b1;
        end else if (cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      RESULT: begin
        if (cnt == '0) begin
          state_n = IDLE;
          p1_n    = 1'b0;
          p2_n    = 1'b0;
          tie_n   = 1'b0;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      default: state_n = IDLE;
    endcase
    go_n = (state_n == GO);
  end

  assign p1vic     = p1_q;
  assign p2vic     = p2_q;
  assign tie       = tie_q;
  assign go_led    = go_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_round_referee.sv
// Directed self-checking bench for round_referee with shortened timing parameters.
module tb_round_referee;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start_btn = 1'b0;
  logic       p1_btn = 1'b0;
  logic       p2_btn = 1'b0;
  logic       game_over = 1'b0;
  logic       p1vic, p2vic, tie, go_led;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_err    = 0;

  localparam logic [31:0] SEED = 32'hACE1_0001;

  always #5 clock = ~clock;

  round_referee #(
    .MIN_DELAY(10), .RAND_BITS(3), .TIMEOUT(20), .HOLD(4), .LFSR_SEED(SEED)
  ) dut (
    .clock(clock), .reset(reset), .start_btn(start_btn), .p1_btn(p1_btn), .p2_btn(p2_btn),
    .game_over(game_over), .p1vic(p1vic), .p2vic(p2vic), .tie(tie), .go_led(go_led),
    .state_dbg(state_dbg)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  function automatic bit sig(input int sel);
    case (sel)
      0: return state_dbg == 2'd1;
      1: return go_led;
      2: return state_dbg == 2'd0;
      3: return p1vic;
      4: return p2vic;
      5: return tie;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input string tag, input int sel, input int budget);
    int k = 0;
    while (!sig(sel) && k < budget) begin
      tick();
      k++;
    end
    chk(tag, sig(sel), 1);
  endtask

  task automatic start_round(input string tag);
    start_btn = 1'b1;
    tick(3);
    start_btn = 1'b0;
    wait_sig({tag, "_enter_wait"}, 0, 5);
  endtask

  // Counts WAIT cycles from the first WAIT sample; ends on the first GO sample.
  task automatic run_wait(input string tag);
    int len = 0;
    while (state_dbg == 2'd1 && len < 40) begin
      len++;
      tick();
    end
    chk({tag, "_wait_len_in_10_17"}, (len >= 10 && len <= 17), 1);
    chk({tag, "_go_led"}, go_led, 1);
  endtask

  task automatic player_press(input string tag, input bit b1, input bit b2, input int sel);
    p1_btn = b1;
    p2_btn = b2;
    tick(2);
    chk({tag, "_latency_not_yet"}, sig(sel), 0);
    tick();
    chk({tag, "_latency_3"}, sig(sel), 1);
    p1_btn = 1'b0;
    p2_btn = 1'b0;
  endtask

  task automatic count_result(input string tag, input int sel);
    int n = 0;
    int bad = 0;
    while (sig(sel) && n < 20) begin
      n++;
      if ((int'(p1vic) + int'(p2vic) + int'(tie)) != 1 || go_led) bad = 1;
      tick();
    end
    chk({tag, "_hold_cycles"}, n, 4);
    chk({tag, "_exclusive"}, bad, 0);
    chk({tag, "_back_idle"}, state_dbg, 0);
    chk({tag, "_outs_low"}, {p1vic, p2vic, tie}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, bad;
    tick(2);
    chk("rst_state", state_dbg, 0);
    chk("rst_outs", {p1vic, p2vic, tie, go_led}, 0);
    chk("rst_lfsr", dut.lfsr, SEED);
    reset = 1'b0;
    tick(2);

    // 1: p1 wins
    start_round("t1");
    run_wait("t1");
    tick(2);
    player_press("t1", 1'b1, 1'b0, 3);
    count_result("t1", 3);

    // 2: simultaneous press -> tie
    tick(2);
    start_round("t2");
    run_wait("t2");
    tick(3);
    player_press("t2", 1'b1, 1'b1, 5);
    count_result("t2", 5);

    // 3: GO timeout
    tick(2);
    start_round("t3");
    run_wait("t3");
    n = 0;
    bad = 0;
    while (go_led && n < 40) begin
      if (p1vic || p2vic || tie) bad = 1;
      n++;
      tick();
    end
    chk("t3_go_cycles", n, 20);
    chk("t3_no_vic", bad, 0);
    chk("t3_idle", state_dbg, 0);

    // 4: p2 presses during WAIT
    tick(2);
    start_round("t4");
`ifdef FALSE_START_PENALTY_EN
    tick(2);
    player_press("t4", 1'b0, 1'b1, 3);
    count_result("t4", 3);
`else
    n = 1;
    bad = 0;
    tick();
    while (state_dbg == 2'd1 && n < 40) begin
      if (n == 2) p2_btn = 1'b1;
      if (n == 5) p2_btn = 1'b0;
      if (p1vic || p2vic || tie) bad = 1;
      n++;
      tick();
    end
    p2_btn = 1'b0;
    chk("t4_wait_len_in_10_17", (n >= 10 && n <= 17), 1);
    chk("t4_no_vic", bad, 0);
    chk("t4_go_led", go_led, 1);
    wait_sig("t4_timeout_idle", 2, 30);
`endif

    // 5: game_over gating
    tick(2);
    game_over = 1'b1;
    start_btn = 1'b1;
    tick(3);
    start_btn = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (state_dbg != 2'd0) bad = 1;
      tick();
    end
    chk("t5_blocked", bad, 0);
    game_over = 1'b0;
    start_round("t5");
    run_wait("t5");
    tick();
    player_press("t5", 1'b0, 1'b1, 4);
    game_over = 1'b1;
    count_result("t5", 4);
    start_btn = 1'b1;
    tick(3);
    start_btn = 1'b0;
    tick(4);
    chk("t5_still_idle", state_dbg, 0);
    game_over = 1'b0;

    // 6: async reset mid-WAIT and mid-RESULT
    tick(2);
    start_round("t6a");
    tick(3);
    #2 reset = 1'b1;
    #1;
    chk("t6a_state", state_dbg, 0);
    chk("t6a_outs", {p1vic, p2vic, tie, go_led}, 0);
    chk("t6a_lfsr", dut.lfsr, SEED);
    tick();
    reset = 1'b0;
    tick(2);
    start_round("t6b");
    run_wait("t6b");
    player_press("t6b", 1'b1, 1'b0, 3);
    tick();
    chk("t6b_in_result", p1vic, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6b_state", state_dbg, 0);
    chk("t6b_outs", {p1vic, p2vic, tie, go_led}, 0);
    chk("t6b_lfsr", dut.lfsr, SEED);
    tick();
    reset = 1'b0;
    tick(3);
    chk("t6b_stays_low", {p1vic, p2vic, tie, go_led}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
